shader_sequencer: RTL
=====================

# shader_sequencer

Parametrised shader/mode sequencer for the HDMI shader pipeline: debounces two active-low buttons (next, prev), walks a configurable list of shader programs and the sub-modes (e.g. convolution kernels) of one designated shader, and drives the shader_select and kernel select lines of the renderer. It adds bidirectional stepping, hold-to-auto-repeat and an optional unattended auto-cycle timer, with registered outputs and zero extra lag between index and select.

## Interface
- NUM_SHADERS, 7: number of list entries (2..16).
- SHADER_MAP, {4'h9,4'h2,4'h4,4'h8,4'h7,4'h3,4'h6}: packed 4-bit shader codes, entry i at bits [4i+3:4i].
- SUB_IDX, 6: list index whose entry has sub-modes.
- NUM_SUB, 4: sub-mode count of SUB_IDX (1..16; 1 = no sub-modes).
- DEBOUNCE_CYCLES, 500000: stable-sample count to accept a button change (>=1).
- REPEAT_DELAY, 12500000: held cycles before the first auto-repeat (0 disables repeat).
- REPEAT_RATE, 5000000: cycles between repeats while held (>=1).
- AUTO_CYCLES, 125000000: idle cycles before an auto step when auto_en=1 (>=1).
- IDX_W = clog2(NUM_SHADERS), SUB_W = max(1,clog2(NUM_SUB)): derived localparams.

Ports:
- clk  in  1  pixel-domain clock.
- rst_n  in  1  reset; asynchronous, active-low.
- btn_next_n  in  1  async button, active-low, pulled up.
- btn_prev_n  in  1  async button, active-low, pulled up.
- auto_en  in  1  level; enables auto-cycle.
- shader_select  out  4  SHADER_MAP code of current index.
- sub_select  out  SUB_W  current sub-mode; 0 unless index==SUB_IDX.
- index  out  IDX_W  current list index.
- step_pulse  out  1  one-cycle strobe on any applied step.

## Operation
- Reset: index=0, sub_select=0, shader_select=SHADER_MAP[3:0], step_pulse=0, both stable button states=1, synchroniser flops=1, all counters=0.
- Each button: 2-flop synchroniser, then debouncer. Counter clears when synced input == stable; else increments. When counter == DEBOUNCE_CYCLES-1 and input still differs, stable flips and counter clears.
- Press event: stable 1->0. Release does nothing.
- Hold repeat (per button, REPEAT_DELAY>0): hold counter runs while stable==0. At REPEAT_DELAY cycles after the press, a repeat event fires; another fires every REPEAT_RATE cycles after that. The hold counter clears on release.
- Request arbitration per cycle: next and prev events in the same cycle cancel (no step). Auto step counts as next and only fires when no button is stable-low.
- Auto timer: counts while auto_en=1. It clears on any step, any press, or auto_en=0. At AUTO_CYCLES-1 it issues a next request and clears.
- Step next:
  - index==SUB_IDX and sub<NUM_SUB-1: sub+1.
  - Otherwise: sub=0 and index+1, wrapping NUM_SHADERS-1 -> 0.
- Step prev:
  - index==SUB_IDX and sub>0: sub-1.
  - Otherwise: index-1, wrapping 0 -> NUM_SHADERS-1. sub = NUM_SUB-1 if the new index==SUB_IDX, else 0.
- shader_select, sub_select and index are registered from the same next-state logic and always change on the same edge. step_pulse=1 for exactly that cycle.
- Index arithmetic is explicit compare-and-wrap, not power-of-two overflow. NUM_SHADERS need not be a power of 2.

## Timing
- Button edge to stable flip: 2 (sync) + DEBOUNCE_CYCLES cycles, given a clean input.
- Stable flip to output update: 1 cycle (event registered, step applied on next edge).
- Glitch shorter than DEBOUNCE_CYCLES: no effect; the counter restarts.
- Repeat timing: first repeat step applied REPEAT_DELAY+1 cycles after the press step; subsequent steps spaced REPEAT_RATE cycles apart.
- Auto step spacing: exactly AUTO_CYCLES cycles between consecutive auto steps.
- rst_n assertion mid-hold or mid-debounce returns all state to reset values immediately. After release, a still-held button is accepted as a new press after 2+DEBOUNCE_CYCLES cycles.
- Outputs never glitch: no combinational path from inputs to outputs.

## Test plan
Bench params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8, AUTO_CYCLES=32, defaults otherwise.
- Reset check: during and after reset, index=0, shader_select=4'h6, sub_select=0, step_pulse=0.
- Debounce: 3-cycle low glitch on next -> no step. Clean press -> index=1, shader_select=4'h3 exactly 7 cycles after the edge, with a single step_pulse.
- Sub-mode walk: 10 presses of next from reset -> index=6, shader_select=4'h9, sub=0,1,2,3 across presses 6-9. Press 10 gives index=0, sub=0.
- Prev wrap: from reset, press prev -> index=6, sub=3. Three more prevs -> sub=0. Next prev -> index=5, shader_select=4'h2.
- Hold repeat: hold next for 60 cycles after debounce -> steps at press, +17, +25, +33, +41, +49, +57 (7 steps total).
- Cancel and auto: next and prev debounced on the same cycle -> no step. auto_en=1 idle for 100 cycles -> 3 auto steps 32 cycles apart. Any press clears the timer.

Source files
------------

// File: rtl/shader_sequencer.sv
// Shader/mode sequencer: debounced next/prev buttons with hold-repeat and an
// optional auto-cycle timer step through a shader list and one shader's sub-modes.
module shader_sequencer #(
  parameter int NUM_SHADERS = 7,
  parameter logic [4*NUM_SHADERS-1:0] SHADER_MAP = {4'h9, 4'h2, 4'h4, 4'h8, 4'h7, 4'h3, 4'h6},
  parameter int SUB_IDX = 6,
  parameter int NUM_SUB = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE = 5000000,
  parameter int AUTO_CYCLES = 125000000,
  localparam int IDX_W = (NUM_SHADERS > 1) ? $clog2(NUM_SHADERS) : 1,
  localparam int SUB_W = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_next_n,
  input  logic             btn_prev_n,
  input  logic             auto_en,
  output logic [3:0]       shader_select,
  output logic [SUB_W-1:0] sub_select,
  output logic [IDX_W-1:0] index,
  output logic             step_pulse
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int HOLD_W = $clog2(HOLD_MAX + 1);
  localparam int AUTO_W = $clog2(AUTO_CYCLES + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DELAY_V   = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] RATE_V    = HOLD_W'(REPEAT_RATE);
  localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_SHADERS - 1);
  localparam logic [IDX_W-1:0]  SUB_AT    = IDX_W'(SUB_IDX);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(NUM_SUB - 1);

  // Bit 0 is the next button, bit 1 the prev button.
  logic [1:0] btn_raw;
  logic [1:0] stable;
  logic [1:0] press;
  logic [1:0] ev;

  assign btn_raw = {btn_prev_n, btn_next_n};

  for (genvar g = 0; g < 2; g++) begin : g_btn
    logic              s1;
    logic              s2;
    logic              stb;
    logic              rep;
    logic              ev_q;
    logic              flip;
    logic              fire;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold;

    assign flip = (s2 != stb) && (db_cnt == DB_LAST);
    // First repeat waits REPEAT_DELAY held cycles, later ones REPEAT_RATE.
    assign fire = !stb && (REPEAT_DELAY != 0) && (rep ? (hold == RATE_V) : (hold == DELAY_V));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1     <= 1'b1;
        s2     <= 1'b1;
        stb    <= 1'b1;
        db_cnt <= '0;
        hold   <= '0;
        rep    <= 1'b0;
        ev_q   <= 1'b0;
      end else begin
        s1 <= btn_raw[g];
        s2 <= s1;
        if (s2 == stb) begin
          db_cnt <= '0;
        end else if (flip) begin
          stb    <= ~stb;
          db_cnt <= '0;
        end else begin
          db_cnt <= db_cnt + DB_W'(1);
        end
        if (stb) begin
          hold <= '0;
          rep  <= 1'b0;
        end else if (fire) begin
          hold <= HOLD_W'(1);
          rep  <= 1'b1;
        end else if (REPEAT_DELAY != 0) begin
          hold <= hold + HOLD_W'(1);
        end
        ev_q <= (flip && stb) || fire;
      end
    end

    assign stable[g] = stb;
    assign press[g]  = flip && stb;
    assign ev[g]     = ev_q;
  end

  logic              any_low;
  logic              auto_hit;
  logic              auto_req;
  logic              req_next;
  logic              req_prev;
  logic              do_next;
  logic              do_prev;
  logic [AUTO_W-1:0] auto_cnt;

  assign any_low  = ~&stable;
  assign auto_hit = (auto_cnt == AUTO_LAST);
  assign auto_req = auto_en && auto_hit && !any_low;
  assign req_next = ev[0] || auto_req;
  assign req_prev = ev[1];
  // Opposing requests in the same cycle cancel each other.
  assign do_next  = req_next && !req_prev;
  assign do_prev  = req_prev && !req_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      auto_cnt <= '0;
    end else if (!auto_en || do_next || do_prev || (|press) || auto_hit) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + AUTO_W'(1);
    end
  end

  logic [IDX_W-1:0] idx_d;
  logic [SUB_W-1:0] sub_d;
  logic [3:0]       shader_d;

  always_comb begin
    idx_d = index;
    sub_d = sub_select;
    if (do_next) begin
      if (index == SUB_AT && sub_select != SUB_LAST) begin
        sub_d = sub_select + SUB_W'(1);
      end else begin
        sub_d = '0;
        idx_d = (index == IDX_LAST) ? '0 : index + IDX_W'(1);
      end
    end else if (do_prev) begin
      if (index == SUB_AT && sub_select != '0) begin
        sub_d = sub_select - SUB_W'(1);
      end else begin
        idx_d = (index == '0) ? IDX_LAST : index - IDX_W'(1);
        sub_d = (idx_d == SUB_AT) ? SUB_LAST : '0;
      end
    end
    // Explicit lookup keeps non-power-of-two list sizes safe.
    shader_d = SHADER_MAP[3:0];
    for (int i = 0; i < NUM_SHADERS; i++) begin
      if (idx_d == IDX_W'(i)) shader_d = SHADER_MAP[4*i +: 4];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index         <= '0;
      sub_select    <= '0;
      shader_select <= SHADER_MAP[3:0];
      step_pulse    <= 1'b0;
    end else begin
      index         <= idx_d;
      sub_select    <= sub_d;
      shader_select <= shader_d;
      step_pulse    <= do_next || do_prev;
    end
  end

endmodule
